// File: rtl/nibble_packer.sv
// nibble_packer: gathers NIB_W-bit slices into WORD_W-bit words.
// Slices arrive over a valid/ready handshake and fill the accumulator in
// LSB-first or MSB-first order. A flush request closes a partial word.
// Completed words sit in a single registered output stage until the
// consumer takes them.
module nibble_packer #(
  parameter  int WORD_W    = 8,
  parameter  int NIB_W     = 4,
  parameter  int MSB_FIRST = 0,
  localparam int NIBS      = WORD_W / NIB_W,
  localparam int CW        = $clog2(NIBS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [NIB_W-1:0]  in_nib,
  input  logic              flush,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [CW-1:0]     out_nibs
);

  logic [WORD_W-1:0] r_acc;
  logic [CW-1:0]     r_idx;
  logic              r_outValid;
  logic [WORD_W-1:0] r_outWord;
  logic [CW-1:0]     r_outNibs;

  logic [WORD_W-1:0] w_merged;
  logic              w_accept;
  logic              w_flushOnly;
  logic              w_lastSlot;
  logic              w_loadSlice;
  logic              w_loadFlush;
  logic              w_load;

  // The output stage can take a new word when empty or draining this cycle;
  // this is the only combinational path from an input to an output.
  assign in_ready    = ~r_outValid | out_ready;
  assign w_accept    = in_valid & in_ready;
  assign w_flushOnly = flush & in_ready & ~in_valid;
  assign w_lastSlot  = (r_idx == CW'(NIBS - 1));
  assign w_loadSlice = w_accept & (w_lastSlot | flush);
  assign w_loadFlush = w_flushOnly & (r_idx != '0);
  assign w_load      = w_loadSlice | w_loadFlush;

  // Accumulator with the incoming slice written into the current slot.
  always_comb begin
    w_merged = r_acc;
    for (int k = 0; k < NIBS; k++) begin
      if (r_idx == CW'(k)) begin
        if (MSB_FIRST != 0)
          w_merged[WORD_W-1-k*NIB_W -: NIB_W] = in_nib;
        else
          w_merged[k*NIB_W +: NIB_W] = in_nib;
      end
    end
  end

  // Accumulator and slot index: cleared whenever a word leaves for the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_idx <= '0;
    end else if (w_load) begin
      r_acc <= '0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_acc <= w_merged;
      r_idx <= r_idx + CW'(1);
    end
  end

  // Output register: a load wins over a drain so words can go back to back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_outWord  <= '0;
      r_outNibs  <= '0;
    end else if (w_load) begin
      r_outValid <= 1'b1;
      r_outWord  <= w_loadSlice ? w_merged : r_acc;
      r_outNibs  <= w_loadSlice ? (r_idx + CW'(1)) : r_idx;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_valid = r_outValid;
  assign out_word  = r_outWord;
  assign out_nibs  = r_outNibs;

endmodule

// File: doc/nibble_packer.md
# nibble_packer

Reassembles a stream of NIB_W-bit slices into WORD_W-bit words; it is the inverse of the slicing dut, which extracts 4-bit fields from an 8-bit word with `+:` / `-:` part-selects. Slices enter over a valid/ready handshake and are written into an accumulator with indexed part-selects in LSB-first or MSB-first order. Completed words leave through a single-entry registered output stage with valid/ready. A flush request emits a partially filled word.

## Interface
- WORD_W, 8: output word width; must be an integer multiple of NIB_W.
- NIB_W, 4: slice width.
- MSB_FIRST, 0: 0 places slice k at `acc[k*NIB_W +: NIB_W]`; 1 places slice k at `acc[WORD_W-1-k*NIB_W -: NIB_W]`.
- Derived: NIBS = WORD_W/NIB_W, which must be ≥ 2. CW = $clog2(NIBS)+1.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_nib is valid.
- in_nib  in  NIB_W  slice data.
- flush  in  1  close the current partial word; qualified by in_ready.
- in_ready  out  1  block accepts a slice and/or a flush this cycle.
- out_valid  out  1  out_word holds a completed word.
- out_ready  in  1  consumer accepts out_word.
- out_word  out  WORD_W  assembled word; unfilled slice positions are zero.
- out_nibs  out  CW  number of slices in out_word (1..NIBS).

## Operation
- State:
  - acc (WORD_W bits)
  - idx (next slot, 0..NIBS-1)
  - out_valid, out_word, out_nibs registers
- in_ready = ~out_valid | out_ready. This is combinational from out_ready. Any slice or flush is stalled while the output stage is full and not draining.
- Slice accept (in_valid & in_ready):
  - in_nib is written into slot idx per MSB_FIRST.
  - If idx == NIBS-1, or flush is asserted in the same cycle:
    - the merged accumulator value is loaded into out_word;
    - out_nibs = idx+1;
    - out_valid is set;
    - acc clears to 0 and idx returns to 0.
  - Otherwise idx increments.
- Flush without a slice (flush & in_ready & ~in_valid):
  - If idx > 0: out_word = acc, out_nibs = idx, out_valid is set, acc and idx clear.
  - If idx == 0: flush is ignored. No empty word is ever emitted.
- Output handshake:
  - out_valid & out_ready clears out_valid next cycle, unless a new word loads in the same cycle.
  - Load and drain in the same cycle: out_valid stays 1 and out_word/out_nibs take the new word. This gives back-to-back words with no bubble.
- While out_valid & ~out_ready: out_word and out_nibs are held stable. in_nib and flush are not sampled.
- Accumulator bits beyond the filled slots are always zero.
- Reset (asynchronous, any time, including mid-word): acc=0, idx=0, out_valid=0, out_word=0, out_nibs=0. A partial word in progress is discarded. in_ready is 1 after reset because out_valid=0.

## Timing
- Latency: out_valid rises on the clock edge that accepts the final slice or the flush. The word is visible the cycle after acceptance.
- Throughput: one slice per cycle sustained with out_ready held high, i.e. one word every NIBS cycles.
- Combinational paths:
  - out_ready → in_ready is the only combinational input-to-output path.
  - out_word, out_nibs and out_valid are driven directly from registers.
- Reset release: the first slice can be accepted on the first rising edge after rst deasserts.

## Test plan
- Default params, LSB-first: slices 0x5 then 0xD on consecutive cycles → out_word=8'b11010101, out_nibs=2, out_valid one cycle after the second accept. Then slices 0xA, 0xA → 8'b10101010.
- MSB_FIRST=1, WORD_W=16: slices 0x1, 0x2, 0x3, 0x4 → out_word=16'h1234, out_nibs=4. Then slices 0xF, 0x0, 0xF, 0x0 back-to-back with out_ready=1 → 16'hF0F0, with no idle cycle between words.
- Backpressure, default params: hold out_ready=0 after word 0xF0 (slices 0x0, 0xF). in_ready must drop, and out_word must hold 0xF0 for 5 cycles while in_valid stays high with 0x3. Release out_ready → 0xF0 drains, then 0x3 is accepted.
- Flush, WORD_W=16, LSB-first:
  - slices 0x7, 0x9, then flush alone → out_word=16'h0097, out_nibs=2;
  - flush with idx=0 → no output;
  - slice 0xB with flush in the same cycle → 16'h000B, out_nibs=1.
- Reset mid-word, default params: accept slice 0xC, assert rst asynchronously → all outputs 0 immediately. After release, slices 0x1, 0x2 → 8'h21. No trace of 0xC appears.
